// File: rtl/mcd212_pkg.sv
// rtl/mcd212_pkg.sv - shared constants and requester indices for the MCD212 bus arbiter
//
// Purpose: requester index enum, requester count, CPU starvation limit and
//          word-address width shared by the arbiter top and its pick logic.
// Ports:   none (package).
package mcd212_pkg;

  localparam int NUM_REQ      = 4;
  localparam int STARVE_LIMIT = 15;
  localparam int ADDR_W       = 22;

  typedef enum logic [1:0] {
    REQ_VSR = 2'd0,  // VSR pixel fetch
    REQ_CHA = 2'd1,  // ICA/DCA channel A
    REQ_CHB = 2'd2,  // ICA/DCA channel B
    REQ_CPU = 2'd3   // CPU
  } req_idx_e;

endpackage

// File: rtl/mcd212_arb_pick.sv
// rtl/mcd212_arb_pick.sv - combinational priority pick for the MCD212 bus arbiter
//
// Purpose: choose one requester from the active strobes.
//          Order: starved CPU > VSR > channels A/B round-robin > CPU.
// Ports:
//   req_as   in  4  per-requester address strobe
//   rr_last  in  1  channel granted most recently (0 = A, 1 = B)
//   starved  in  1  CPU has waited long enough to jump the queue
//   pick     out 4  one-hot choice, all-zero when nobody requests
module mcd212_arb_pick
  import mcd212_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_as,
  input  logic               rr_last,
  input  logic               starved,
  output logic [NUM_REQ-1:0] pick
);

  always_comb begin
    pick = '0;
    if (starved && req_as[REQ_CPU]) begin
      pick[REQ_CPU] = 1'b1;
    end else if (req_as[REQ_VSR]) begin
      pick[REQ_VSR] = 1'b1;
    end else if (req_as[REQ_CHA] && req_as[REQ_CHB]) begin
      // Both channels want the bus: favour the one that did not go last.
      if (rr_last) pick[REQ_CHA] = 1'b1;
      else         pick[REQ_CHB] = 1'b1;
    end else if (req_as[REQ_CHA]) begin
      pick[REQ_CHA] = 1'b1;
    end else if (req_as[REQ_CHB]) begin
      pick[REQ_CHB] = 1'b1;
    end else if (req_as[REQ_CPU]) begin
      pick[REQ_CPU] = 1'b1;
    end
  end

endmodule

// File: rtl/mcd212_bus_arbiter.sv
// rtl/mcd212_bus_arbiter.sv - four-way shared memory bus arbiter for the MCD212
//
// Purpose: grants the shared memory bus to one of VSR, channel A, channel B
//          or CPU, holds ownership while the owner keeps its strobe high and
//          steers the owner's address/strobe to memory and mem_ack back.
// Ports:
//   clk          in  1      clock
//   reset        in  1      synchronous active-high reset
//   req_address  in  4x22   per-requester word address
//   req_as       in  4      per-requester address strobe
//   req_din      out 16     broadcast read data
//   req_bus_ack  out 4      per-requester acknowledge (owner only)
//   mem_address  out 22     shared memory address
//   mem_as       out 1      shared memory strobe
//   mem_din      in  16     shared memory read data
//   mem_ack      in  1      shared memory acknowledge
//   grant        out 4      registered one-hot owner, zero when idle
module mcd212_bus_arbiter
  import mcd212_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_address,
  input  logic [NUM_REQ-1:0]             req_as,
  output logic [15:0]                    req_din,
  output logic [NUM_REQ-1:0]             req_bus_ack,
  output logic [ADDR_W-1:0]              mem_address,
  output logic                           mem_as,
  input  logic [15:0]                    mem_din,
  input  logic                           mem_ack,
  output logic [NUM_REQ-1:0]             grant
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  logic [0:0]         state;
  logic [NUM_REQ-1:0] grant_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [3:0]         starve_cnt;
  logic               rr_last;
  logic [NUM_REQ-1:0] pick;
  logic [1:0]         owner;
  logic               owned;
  logic               owner_as;
  logic               starved;

  mcd212_arb_pick u_pick (
    .req_as  (req_as),
    .rr_last (rr_last),
    .starved (starved),
    .pick    (pick)
  );

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) owner = 2'(i);
    end
  end

  assign owned    = (state == ST_OWNED);
  assign owner_as = req_as[owner];
  assign starved  = (starve_cnt == 4'(STARVE_LIMIT));

  // While idle the address bus parks on whatever the last owner drove.
  assign mem_address = owned ? req_address[owner] : addr_q;
  assign mem_as      = owned & owner_as;
  // Gating with reset drops an ack that would land on the reset cycle.
  assign req_bus_ack = (owned && mem_ack && !reset) ? grant_q : '0;
  assign req_din     = mem_din;
  assign grant       = grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant_q    <= '0;
      addr_q     <= '0;
      starve_cnt <= '0;
      rr_last    <= 1'b1;  // pretend B went last so A is favoured first
    end else begin
      if (req_as[REQ_CPU] && !grant_q[REQ_CPU]) begin
        if (!starved) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (|req_as) begin
            grant_q <= pick;
            state   <= ST_OWNED;
            if (pick[REQ_CHA])      rr_last <= 1'b0;
            else if (pick[REQ_CHB]) rr_last <= 1'b1;
          end
        end
        ST_OWNED: begin
          addr_q <= req_address[owner];
          // Release takes a full cycle so handovers always pass through IDLE.
          if (!owner_as) begin
            state   <= ST_IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule
